mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one memory command port between a buffered capture write stream and a readback requester.
// Define ARB_STARVE_GUARD_EN to build the read starvation guard; otherwise writes have strict priority.
module mem_port_arbiter #(
  parameter int PACKET_WIDTH = 32,
  parameter int FIFO_DEPTH   = 8,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_valid,
  input  logic [PACKET_WIDTH-1:0] wr_data,
  input  logic [26:0]             wr_addr,
  input  logic                    rd_req,
  input  logic [26:0]             rd_addr,
  output logic                    rd_grant,
  output logic                    mem_cmd_valid,
  input  logic                    mem_cmd_ready,
  output logic                    mem_cmd_we,
  output logic [26:0]             mem_cmd_addr,
  output logic [PACKET_WIDTH-1:0] mem_cmd_data,
  output logic [7:0]              fifo_level,
  output logic                    wr_overflow,
  output logic                    busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ
  } state_e;

  state_e                  state_q;
  logic                    cmd_valid_q;
  logic                    cmd_we_q;
  logic [26:0]             cmd_addr_q;
  logic [PACKET_WIDTH-1:0] cmd_data_q;
  logic                    grant_q;
  logic                    ovf_q;

  logic                    stg_valid_q;
  logic [26:0]             stg_addr_q;
  logic [PACKET_WIDTH-1:0] stg_data_q;

  logic [PW-1:0]           wptr_q;
  logic [PW-1:0]           rptr_q;
  logic [PW-1:0]           count;
  logic [26:0]             addr_mem [FIFO_DEPTH];
  logic [PACKET_WIDTH-1:0] data_mem [FIFO_DEPTH];

  logic empty;
  logic full;
  logic pop;
  logic push;
  logic drop;
  logic read_ok;
  logic forced;

  assign count = wptr_q - rptr_q;
  assign empty = (count == '0);
  assign full  = (count == PW'(FIFO_DEPTH));
  assign pop   = (state_q == WRITE) && cmd_valid_q && mem_cmd_ready;
  assign push  = stg_valid_q && (!full || pop);
  assign drop  = stg_valid_q && full && !pop;

  // Grant is registered one cycle after acceptance; while it is high the
  // requester may still hold rd_req, so that cycle must not start a read.
  assign read_ok = rd_req && !grant_q;

`ifdef ARB_STARVE_GUARD_EN
  logic [7:0] starve_q;

  assign forced = read_ok && (starve_q >= 8'(STARVE_LIMIT));

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else if (!rd_req || grant_q) begin
      starve_q <= '0;
    end else if (starve_q < 8'(STARVE_LIMIT)) begin
      starve_q <= starve_q + 8'd1;
    end
  end
`else
  assign forced = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wptr_q[AW-1:0]] <= stg_addr_q;
      data_mem[wptr_q[AW-1:0]] <= stg_data_q;
    end
  end

  // Capture packets land in a staging register and enter the FIFO one edge later.
  always_ff @(posedge clk) begin
    if (reset) begin
      stg_valid_q <= 1'b0;
      stg_addr_q  <= '0;
      stg_data_q  <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      stg_valid_q <= wr_valid;
      stg_addr_q  <= wr_addr;
      stg_data_q  <= wr_data;
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      if (drop) ovf_q  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_valid_q <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_data_q  <= '0;
      grant_q     <= 1'b0;
    end else begin
      grant_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!empty && !forced) begin
            state_q     <= WRITE;
            cmd_valid_q <= 1'b1;
            cmd_we_q    <= 1'b1;
            cmd_addr_q  <= addr_mem[rptr_q[AW-1:0]];
            cmd_data_q  <= data_mem[rptr_q[AW-1:0]];
          end else if (read_ok) begin
            state_q     <= READ;
            cmd_valid_q <= 1'b1;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= rd_addr;
            cmd_data_q  <= '0;
          end
        end
        WRITE: begin
          if (mem_cmd_ready) begin
            state_q     <= IDLE;
            cmd_valid_q <= 1'b0;
            cmd_we_q    <= 1'b0;
          end
        end
        READ: begin
          if (mem_cmd_ready) begin
            state_q     <= IDLE;
            cmd_valid_q <= 1'b0;
            grant_q     <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          cmd_valid_q <= 1'b0;
          cmd_we_q    <= 1'b0;
        end
      endcase
    end
  end

  assign rd_grant      = grant_q;
  assign mem_cmd_valid = cmd_valid_q;
  assign mem_cmd_we    = cmd_we_q;
  assign mem_cmd_addr  = cmd_addr_q;
  assign mem_cmd_data  = cmd_data_q;
  assign fifo_level    = 8'(count);
  assign wr_overflow   = ovf_q;
  assign busy          = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_mem_port_arbiter;

  localparam int PWD   = 32;
  localparam int DEPTH = 8;
  localparam int LIMIT = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic           clk;
  logic           reset;
  logic           wr_valid;
  logic [PWD-1:0] wr_data;
  logic [26:0]    wr_addr;
  logic           rd_req;
  logic [26:0]    rd_addr;
  logic           rd_grant;
  logic           mem_cmd_valid;
  logic           mem_cmd_ready;
  logic           mem_cmd_we;
  logic [26:0]    mem_cmd_addr;
  logic [PWD-1:0] mem_cmd_data;
  logic [7:0]     fifo_level;
  logic           wr_overflow;
  logic           busy;

  mem_port_arbiter #(
    .PACKET_WIDTH(PWD),
    .FIFO_DEPTH  (DEPTH),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .wr_addr      (wr_addr),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_grant     (rd_grant),
    .mem_cmd_valid(mem_cmd_valid),
    .mem_cmd_ready(mem_cmd_ready),
    .mem_cmd_we   (mem_cmd_we),
    .mem_cmd_addr (mem_cmd_addr),
    .mem_cmd_data (mem_cmd_data),
    .fifo_level   (fifo_level),
    .wr_overflow  (wr_overflow),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // Reference model: mode 0=idle, 1=write, 2=read; FIFO is a queue of {addr,data}.
  logic [58:0] mq[$];
  int          m_mode   = 0;
  logic        m_valid  = 0;
  logic        m_we     = 0;
  logic [26:0] m_addr   = 0;
  logic [31:0] m_data   = 0;
  logic        m_grant  = 0;
  logic        m_ovf    = 0;
  int          m_starve = 0;
  logic        s_v      = 0;
  logic [26:0] s_a      = 0;
  logic [31:0] s_d      = 0;

  always @(posedge clk) begin
    bit          was_empty;
    bit          pop;
    bit          fr;
    bit          ngrant;
    logic [58:0] head;
    if (reset) begin
      mq.delete();
      m_mode = 0; m_valid = 0; m_we = 0; m_addr = 0; m_data = 0;
      m_grant = 0; m_ovf = 0; m_starve = 0;
      s_v = 0; s_a = 0; s_d = 0;
    end else begin
      was_empty = (mq.size() == 0);
      head = was_empty ? 59'd0 : mq[0];
      pop = (m_mode == 1) && mem_cmd_ready;
      fr = GUARD && rd_req && !m_grant && (m_starve >= LIMIT);
      ngrant = (m_mode == 2) && mem_cmd_ready;
      if (pop) void'(mq.pop_front());
      if (s_v) begin
        if (mq.size() < DEPTH) mq.push_back({s_a, s_d});
        else m_ovf = 1;
      end
      if (GUARD) begin
        if (!rd_req || m_grant) m_starve = 0;
        else if (m_starve < LIMIT) m_starve = m_starve + 1;
      end
      case (m_mode)
        0: begin
          if (!was_empty && !fr) begin
            m_mode = 1; m_valid = 1; m_we = 1;
            m_addr = head[58:32]; m_data = head[31:0];
          end else if (rd_req && !m_grant) begin
            m_mode = 2; m_valid = 1; m_we = 0;
            m_addr = rd_addr; m_data = 0;
          end
        end
        1: if (mem_cmd_ready) begin m_mode = 0; m_valid = 0; m_we = 0; end
        default: if (mem_cmd_ready) begin m_mode = 0; m_valid = 0; end
      endcase
      m_grant = ngrant;
      s_v = wr_valid; s_a = wr_addr; s_d = wr_data;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_valid", mem_cmd_valid, m_valid);
      chk("cyc_we", mem_cmd_we, m_we);
      chk("cyc_addr", mem_cmd_addr, m_addr);
      chk("cyc_data", mem_cmd_data, m_data);
      chk("cyc_grant", rd_grant, m_grant);
      chk("cyc_level", fifo_level, mq.size());
      chk("cyc_ovf", wr_overflow, m_ovf);
      chk("cyc_busy", busy, (m_mode != 0) || (mq.size() != 0));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          n;
    int          reads;
    int          grants;
    int          issued;
    logic [7:0]  lvl;
    logic [26:0] raddr;
    logic [26:0] got_a[8];
    logic [31:0] got_d[8];

    reset = 1; wr_valid = 0; wr_data = 0; wr_addr = 0;
    rd_req = 0; rd_addr = 0; mem_cmd_ready = 0;
    @(negedge clk);
    @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_valid", mem_cmd_valid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", wr_overflow, 0);
    reset = 0;
    @(negedge clk);

    // Single write: latency and data path
    mem_cmd_ready = 1;
    wr_valid = 1; wr_addr = 27'h10; wr_data = 32'hA5A5;
    @(negedge clk);
    wr_valid = 0;
    @(negedge clk);
    chk("lat_k1_valid", mem_cmd_valid, 0);
    chk("lat_k1_level", fifo_level, 1);
    @(negedge clk);
    chk("lat_k2_valid", mem_cmd_valid, 1);
    chk("lat_k2_we", mem_cmd_we, 1);
    chk("lat_k2_addr", mem_cmd_addr, 27'h10);
    chk("lat_k2_data", mem_cmd_data, 32'hA5A5);
    @(negedge clk);
    chk("lat_k3_valid", mem_cmd_valid, 0);
    chk("lat_k3_level", fifo_level, 0);

    // Fill past depth with the port stalled, then drain in order
    mem_cmd_ready = 0;
    for (int i = 0; i < 9; i++) begin
      wr_valid = 1; wr_addr = 27'h100 + 27'(i); wr_data = 32'hC000 + 32'(i);
      @(negedge clk);
    end
    wr_valid = 0;
    @(negedge clk);
    @(negedge clk);
    chk("full_level", fifo_level, 8);
    chk("full_ovf", wr_overflow, 1);
    chk("full_head", mem_cmd_addr, 27'h100);
    mem_cmd_ready = 1;
    n = 0;
    for (int c = 0; c < 40 && n < 8; c++) begin
      if (mem_cmd_valid && mem_cmd_we) begin
        got_a[n] = mem_cmd_addr; got_d[n] = mem_cmd_data; n++;
      end
      @(negedge clk);
    end
    chk("drain_count", n, 8);
    for (int i = 0; i < 8; i++) begin
      chk("drain_addr", got_a[i], 27'h100 + 27'(i));
      chk("drain_data", got_d[i], 32'hC000 + 32'(i));
    end
    chk("drain_level", fifo_level, 0);
    chk("drain_ovf_sticky", wr_overflow, 1);

    // Read on empty FIFO
    rd_req = 1; rd_addr = 27'h200;
    reads = 0; grants = 0; raddr = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (mem_cmd_valid && !mem_cmd_we) begin reads++; raddr = mem_cmd_addr; end
      if (rd_grant) begin grants++; rd_req = 0; end
    end
    rd_req = 0;
    chk("rd_reads", reads, 1);
    chk("rd_addr", raddr, 27'h200);
    chk("rd_grants", grants, 1);

    // Continuous writes competing with a read
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1; wr_addr = 27'h400 + 27'(i); wr_data = 32'hD000 + 32'(i);
      @(negedge clk);
    end
    rd_req = 1; rd_addr = 27'h300;
`ifdef ARB_STARVE_GUARD_EN
    issued = 0; grants = 0; lvl = 0;
    for (int i = 1; i <= 12; i++) begin
      wr_addr = 27'h410 + 27'(i); wr_data = 32'hD100 + 32'(i);
      @(negedge clk);
      if (issued == 0 && mem_cmd_valid && !mem_cmd_we) begin
        issued = i; lvl = fifo_level;
      end
      if (rd_grant) begin grants++; rd_req = 0; end
    end
    chk("starve_latency_ok", (issued >= 5) && (issued <= 6), 1);
    chk("starve_fifo_busy", lvl != 0, 1);
    chk("starve_grants", grants, 1);
    wr_valid = 0;
    rd_req = 0;
`else
    reads = 0; grants = 0;
    for (int i = 1; i <= 20; i++) begin
      wr_addr = 27'h410 + 27'(i); wr_data = 32'hD100 + 32'(i);
      @(negedge clk);
      if (mem_cmd_valid && !mem_cmd_we) reads++;
      if (rd_grant) grants++;
    end
    chk("prio_no_read", reads, 0);
    chk("prio_no_grant", grants, 0);
    wr_valid = 0;
    lvl = 8'hFF; grants = 0;
    for (int c = 0; c < 60 && grants == 0; c++) begin
      @(negedge clk);
      if (mem_cmd_valid && !mem_cmd_we) lvl = fifo_level;
      if (rd_grant) begin grants++; rd_req = 0; end
    end
    rd_req = 0;
    chk("prio_read_level", lvl, 0);
    chk("prio_grant", grants, 1);
`endif
    n = 0;
    for (int c = 0; c < 60 && n == 0; c++) begin
      @(negedge clk);
      if (fifo_level == 0 && !busy) n = 1;
    end
    chk("compete_drained", n, 1);

    // Reset while a write is stalled
    mem_cmd_ready = 0;
    wr_valid = 1; wr_addr = 27'h55; wr_data = 32'h1234;
    @(negedge clk);
    wr_valid = 0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("stall_valid", mem_cmd_valid, 1);
    reset = 1;
    @(negedge clk);
    chk("rstmid_valid", mem_cmd_valid, 0);
    chk("rstmid_level", fifo_level, 0);
    chk("rstmid_ovf", wr_overflow, 0);
    chk("rstmid_busy", busy, 0);
    reset = 0;
    @(negedge clk);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
